// File: rtl/n_by_one_mux_reg.sv
// rtl/n_by_one_mux_reg.sv - N-to-1 registered channel mux with select register; MUX_RR_EN adds round-robin select advance
module n_by_one_mux_reg #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 3,
    localparam int SEL_W   = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      sel_load,
`ifdef MUX_RR_EN
    input  logic                      mode_rr,
`endif
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      sel_err,
    output logic [SEL_W-1:0]          sel_cur,
    output logic [15:0]               xfer_cnt
);

    logic [SEL_W-1:0] sel_cur_q, sel_cur_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             sel_err_q, sel_err_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    logic [WIDTH-1:0] cur_data;
    logic             cur_valid;
    logic             can_take;
    logic             accept;
    logic             sel_in_range;

    // Output register is free when empty or being drained this cycle; held low in reset
    assign can_take     = rst_n & (~out_valid_q | out_ready);
    assign accept       = cur_valid & can_take;
    assign sel_in_range = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));

    // Route the currently selected channel's data and valid
    always_comb begin
        cur_data  = '0;
        cur_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_cur_q == SEL_W'(i)) begin
                cur_data  = in_data[i*WIDTH +: WIDTH];
                cur_valid = in_valid[i];
            end
        end
    end

    // Only the selected channel ever sees ready
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = can_take & (sel_cur_q == SEL_W'(i));
        end
    end

`ifdef MUX_RR_EN
    logic [SEL_W-1:0] rr_next;
    int               rr_dist;
    int               rr_best;

    // Nearest valid channel strictly above sel_cur, wrapping; stay put when none
    always_comb begin
        rr_next = sel_cur_q;
        rr_best = CHANNELS;
        rr_dist = 0;
        for (int j = 0; j < CHANNELS; j++) begin
            rr_dist = j - int'(sel_cur_q);
            if (rr_dist < 0) begin
                rr_dist = rr_dist + CHANNELS;
            end
            if (in_valid[j] && (rr_dist != 0) && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_next = SEL_W'(j);
            end
        end
    end
`endif

    // Next state: accept loads output, drain clears it, select updates after this cycle's accept
    always_comb begin
        sel_cur_d   = sel_cur_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        xfer_cnt_d  = xfer_cnt_q;
        sel_err_d   = sel_load & ~sel_in_range;

        if (accept) begin
            out_data_d  = cur_data;
            out_valid_d = 1'b1;
            xfer_cnt_d  = xfer_cnt_q + 16'd1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (sel_load) begin
            if (sel_in_range) begin
                sel_cur_d = sel;
            end
        end
`ifdef MUX_RR_EN
        else if (mode_rr && accept) begin
            sel_cur_d = rr_next;
        end
`endif
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_cur_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sel_err_q   <= 1'b0;
            xfer_cnt_q  <= '0;
        end else begin
            sel_cur_q   <= sel_cur_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sel_err_q   <= sel_err_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign sel_cur   = sel_cur_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_n_by_one_mux_reg.sv
// tb/tb_n_by_one_mux_reg.sv - self-checking bench for n_by_one_mux_reg with a behavioural reference model
module tb_n_by_one_mux_reg;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 3;
`ifdef MUX_RR_EN
    localparam bit RR_ON = 1'b1;
`else
    localparam bit RR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] in_data;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [1:0]  sel;
    logic        sel_load;
    logic        mode_rr;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sel_err;
    logic [1:0]  sel_cur;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic        m_valid;
    logic [7:0]  m_data;
    int          m_sel;
    logic        m_err;
    logic [15:0] m_cnt;

    always #5 clk = ~clk;

    n_by_one_mux_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_load  (sel_load),
`ifdef MUX_RR_EN
        .mode_rr   (mode_rr),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel_err   (sel_err),
        .sel_cur   (sel_cur),
        .xfer_cnt  (xfer_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_ready();
        return (!m_valid || out_ready) ? 3'(1 << m_sel) : 3'b000;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_sel   = 0;
        m_err   = 1'b0;
        m_cnt   = 16'h0000;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(m_data));
        check({tag, ".sel_cur"},   32'(sel_cur),   32'(m_sel));
        check({tag, ".sel_err"},   32'(sel_err),   32'(m_err));
        check({tag, ".xfer_cnt"},  32'(xfer_cnt),  32'(m_cnt));
    endtask

    // Called at a falling edge with inputs already driven; advances one clock
    task automatic cycle(input string tag);
        logic acc;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready()));
        acc   = in_valid[m_sel] && (exp_ready() != 3'b000);
        m_err = sel_load && (int'(sel) >= CHANNELS);
        if (acc) begin
            m_data  = in_data[m_sel*8 +: 8];
            m_valid = 1'b1;
            m_cnt   = m_cnt + 16'd1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        if (sel_load) begin
            if (int'(sel) < CHANNELS) m_sel = int'(sel);
        end else if (RR_ON && mode_rr && acc) begin
            for (int k = 1; k < CHANNELS; k++) begin
                if (in_valid[(m_sel + k) % CHANNELS]) begin
                    m_sel = (m_sel + k) % CHANNELS;
                    break;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        in_data   = '0;
        in_valid  = '0;
        sel       = '0;
        sel_load  = 1'b0;
        out_ready = 1'b0;
        mode_rr   = 1'b0;
        rst_n     = 1'b0;
        model_reset();

        repeat (2) @(negedge clk);
        check_regs("reset");
        check("reset.in_ready", 32'(in_ready), 32'h0);
        rst_n = 1'b1;
        #1;
        check("first.in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);

        // Basic load and accept on channel 1
        sel = 2'd1; sel_load = 1'b1; out_ready = 1'b1;
        cycle("load1");
        check("load1.sel_cur", 32'(sel_cur), 32'd1);
        sel_load = 1'b0; in_data = 24'h00A500; in_valid = 3'b010;
        cycle("acc_a5");
        check("acc_a5.data", 32'(out_data), 32'hA5);
        check("acc_a5.valid", 32'(out_valid), 32'h1);
        check("acc_a5.cnt", 32'(xfer_cnt), 32'd1);

        // Backpressure holds the word, then drain plus accept in one cycle
        in_data = 24'h005A00; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("stall");
            check("stall.in_ready", 32'(in_ready), 32'h0);
            check("stall.data", 32'(out_data), 32'hA5);
        end
        out_ready = 1'b1;
        cycle("drain");
        check("drain.data", 32'(out_data), 32'h5A);
        check("drain.cnt", 32'(xfer_cnt), 32'd2);

        // Out-of-range select
        in_valid = 3'b000; sel = 2'd3; sel_load = 1'b1;
        cycle("bad_sel");
        check("bad_sel.err", 32'(sel_err), 32'h1);
        check("bad_sel.cur", 32'(sel_cur), 32'd1);
        sel_load = 1'b0;
        cycle("bad_sel_after");
        check("bad_sel_after.err", 32'(sel_err), 32'h0);
        sel = 2'd2; sel_load = 1'b1;
        cycle("sel2");
        check("sel2.cur", 32'(sel_cur), 32'd2);
        sel_load = 1'b0;

`ifdef MUX_RR_EN
        // Round-robin over channels 0 and 2 only
        sel = 2'd0; sel_load = 1'b1;
        cycle("rr_load");
        sel_load = 1'b0; mode_rr = 1'b1; in_valid = 3'b101; in_data = 24'hC2C1C0;
        for (int i = 0; i < 6; i++) begin
            check("rr.sel_cur", 32'(sel_cur), (i % 2 == 0) ? 32'd0 : 32'd2);
            cycle("rr");
            check("rr.data", 32'(out_data), (i % 2 == 0) ? 32'hC0 : 32'hC2);
        end
        mode_rr = 1'b0;
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            in_data   = 24'($urandom);
            in_valid  = 3'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sel_load  = ($urandom_range(0, 7) == 0);
            sel       = 2'($urandom);
            mode_rr   = 1'($urandom);
            cycle("rand");
        end
        mode_rr = 1'b0;

        // Asynchronous reset while a word is held
        sel_load = 1'b0; in_valid = 3'b111; in_data = 24'h123456; out_ready = 1'b1;
        cycle("pre_rst_a");
        out_ready = 1'b0;
        cycle("pre_rst_b");
        check("pre_rst.valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid", 32'(out_valid), 32'h0);
        check("async_rst.data", 32'(out_data), 32'h0);
        check("async_rst.sel_cur", 32'(sel_cur), 32'h0);
        check("async_rst.cnt", 32'(xfer_cnt), 32'h0);
        check("async_rst.in_ready", 32'(in_ready), 32'h0);
        model_reset();
        @(negedge clk);
        in_valid = 3'b000;
        rst_n = 1'b1;
        #1;
        check("release.in_ready", 32'(in_ready), 32'h1);
        @(negedge clk);
        check_regs("release");

        // Counter wrap after 65536 accepts
        in_valid = 3'b001; out_ready = 1'b1; in_data = 24'h0000EE;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        check("wrap.ffff", 32'(xfer_cnt), 32'hFFFF);
        @(posedge clk);
        @(negedge clk);
        check("wrap.zero", 32'(xfer_cnt), 32'h0);
        check("wrap.valid", 32'(out_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
